vga_timing_gen: RTL and testbench

- Generates raster timing for the video path: pixel/line counters, hsync/vsync, active-video flag and frame events.
- Sits directly upstream of the GPU status register, which samples `pixel` and `line` from this block. Also feeds the framebuffer scan-out.
- Runs on the single system clock. The pixel rate comes from an internal clock-enable divider.

---
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters driven by a clock-enable divider.
// Every output is registered and decoded from the next counter state, so all outputs stay aligned with pixel/line.
module vga_timing_gen #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] pixel,
  output logic [15:0] line,
  output logic        pixel_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start,
  output logic        vblank_irq,
  output logic [15:0] frame_count
);

  localparam logic [15:0] DIV_LAST_C = 16'(CLK_DIV - 1);
  localparam logic [15:0] H_ACT_C    = 16'(H_ACTIVE);
  localparam logic [15:0] HS_START_C = 16'(H_ACTIVE + H_FRONT);
  localparam logic [15:0] HS_END_C   = 16'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [15:0] H_LAST_C   = 16'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [15:0] V_ACT_C    = 16'(V_ACTIVE);
  localparam logic [15:0] VS_START_C = 16'(V_ACTIVE + V_FRONT);
  localparam logic [15:0] VS_END_C   = 16'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [15:0] V_LAST_C   = 16'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [15:0] div_cnt_r;
  logic [15:0] pixel_r;
  logic [15:0] line_r;
  logic [15:0] frame_cnt_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        active_r;
  logic        tick_r;
  logic        frame_start_r;
  logic        vblank_r;

  logic        tick_s;
  logic        frame_wrap_s;
  logic [15:0] pix_nxt_s;
  logic [15:0] line_nxt_s;
  logic        hsync_nxt_s;
  logic        vsync_nxt_s;
  logic        active_nxt_s;
  logic        vblank_nxt_s;

  assign tick_s = enable && (div_cnt_r == DIV_LAST_C);

  // Next raster position; the counters only move on a pixel tick.
  always_comb begin
    pix_nxt_s    = pixel_r;
    line_nxt_s   = line_r;
    frame_wrap_s = 1'b0;
    if (tick_s) begin
      if (pixel_r == H_LAST_C) begin
        pix_nxt_s = 16'd0;
        if (line_r == V_LAST_C) begin
          line_nxt_s   = 16'd0;
          frame_wrap_s = 1'b1;
        end else begin
          line_nxt_s = line_r + 16'd1;
        end
      end else begin
        pix_nxt_s = pixel_r + 16'd1;
      end
    end else begin
      pix_nxt_s  = pixel_r;
      line_nxt_s = line_r;
    end
  end

  // Decode syncs, active and vblank from the next position so they land with it.
  always_comb begin
    hsync_nxt_s  = ~HSYNC_POL;
    vsync_nxt_s  = ~VSYNC_POL;
    active_nxt_s = 1'b0;
    vblank_nxt_s = 1'b0;
    if ((pix_nxt_s >= HS_START_C) && (pix_nxt_s < HS_END_C)) begin
      hsync_nxt_s = HSYNC_POL;
    end else begin
      hsync_nxt_s = ~HSYNC_POL;
    end
    if ((line_nxt_s >= VS_START_C) && (line_nxt_s < VS_END_C)) begin
      vsync_nxt_s = VSYNC_POL;
    end else begin
      vsync_nxt_s = ~VSYNC_POL;
    end
    if ((pix_nxt_s < H_ACT_C) && (line_nxt_s < V_ACT_C)) begin
      active_nxt_s = 1'b1;
    end else begin
      active_nxt_s = 1'b0;
    end
    if (tick_s && (pix_nxt_s == 16'd0) && (line_nxt_s == V_ACT_C)) begin
      vblank_nxt_s = 1'b1;
    end else begin
      vblank_nxt_s = 1'b0;
    end
  end

  // State and output registers; the divider phase is held while disabled.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      div_cnt_r     <= 16'd0;
      pixel_r       <= 16'd0;
      line_r        <= 16'd0;
      frame_cnt_r   <= 16'd0;
      hsync_r       <= ~HSYNC_POL;
      vsync_r       <= ~VSYNC_POL;
      active_r      <= 1'b1;
      tick_r        <= 1'b0;
      frame_start_r <= 1'b0;
      vblank_r      <= 1'b0;
    end else begin
      if (enable) begin
        div_cnt_r <= tick_s ? 16'd0 : (div_cnt_r + 16'd1);
      end else begin
        div_cnt_r <= div_cnt_r;
      end
      if (frame_wrap_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      pixel_r       <= pix_nxt_s;
      line_r        <= line_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vsync_r       <= vsync_nxt_s;
      active_r      <= active_nxt_s;
      tick_r        <= tick_s;
      frame_start_r <= frame_wrap_s;
      vblank_r      <= vblank_nxt_s;
    end
  end

  assign pixel       = pixel_r;
  assign line        = line_r;
  assign pixel_tick  = tick_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign active      = active_r;
  assign frame_start = frame_start_r;
  assign vblank_irq  = vblank_r;
  assign frame_count = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a default-V/short-H frame
// instance, and a tiny corner-parameter instance with inverted hsync polarity.
module tb_vga_timing_gen;

  logic cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic rst_a, en_a, rst_b, en_b, rst_c, en_c;
  logic [15:0] pixel_a, line_a, fc_a, pixel_b, line_b, fc_b, pixel_c, line_c, fc_c;
  logic tick_a, hs_a, vs_a, act_a, fs_a, vb_a;
  logic tick_b, hs_b, vs_b, act_b, fs_b, vb_b;
  logic tick_c, hs_c, vs_c, act_c, fs_c, vb_c;

  vga_timing_gen dut_a (
    .cpu_clk(cpu_clk), .reset(rst_a), .enable(en_a), .pixel(pixel_a), .line(line_a),
    .pixel_tick(tick_a), .hsync(hs_a), .vsync(vs_a), .active(act_a),
    .frame_start(fs_a), .vblank_irq(vb_a), .frame_count(fc_a));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2)) dut_b (
    .cpu_clk(cpu_clk), .reset(rst_b), .enable(en_b), .pixel(pixel_b), .line(line_b),
    .pixel_tick(tick_b), .hsync(hs_b), .vsync(vs_b), .active(act_b),
    .frame_start(fs_b), .vblank_irq(vb_b), .frame_count(fc_b));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HSYNC_POL(1'b1)) dut_c (
    .cpu_clk(cpu_clk), .reset(rst_c), .enable(en_c), .pixel(pixel_c), .line(line_c),
    .pixel_tick(tick_c), .hsync(hs_c), .vsync(vs_c), .active(act_c),
    .frame_start(fs_c), .vblank_irq(vb_c), .frame_count(fc_c));

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  int n_tick, prev_p, prev_l, found, errs;
  int hs_first, hs_last, hs_n, ia_first, ia_n;
  int vs_first, vs_last, vb_n, vb_p, vb_l, fs1, fs2, p14, l14;
  logic hs_snap, vs_snap, act_snap, exp_bit;

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    rst_c = 1'b1; en_c = 1'b0;
    cyc(2);

    // reset state of the default instance
    check("rst pixel", int'(pixel_a), 0);
    check("rst line", int'(line_a), 0);
    check("rst frame_count", int'(fc_a), 0);
    check("rst hsync", int'(hs_a), 1);
    check("rst vsync", int'(vs_a), 1);
    check("rst active", int'(act_a), 1);
    check("rst pulses", int'(tick_a) + int'(fs_a) + int'(vb_a), 0);

    // first tick lands on the 4th edge, then one tick every 4 cycles
    rst_a = 1'b0; en_a = 1'b1;
    n_tick = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_tick += int'(tick_a);
    end
    check("early ticks", n_tick, 0);
    check("early pixel", int'(pixel_a), 0);
    cyc(1);
    check("first tick", int'(tick_a), 1);
    check("first pixel", int'(pixel_a), 1);
    n_tick = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      n_tick += int'(tick_a);
    end
    check("ticks in 8 cycles", n_tick, 2);
    check("pixel after 8", int'(pixel_a), 3);
    check("line stays 0", int'(line_a), 0);

    // scan rest of line 0 for horizontal decode, then the wrap to line 1
    hs_first = -1; hs_last = -1; hs_n = 0; ia_first = -1; ia_n = 0; found = 0; prev_p = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      prev_p = int'(pixel_a);
      cyc(1);
      if (line_a == 16'd1) begin
        found = 1;
      end else if (tick_a) begin
        if (!hs_a) begin
          if (hs_first < 0) hs_first = int'(pixel_a);
          hs_last = int'(pixel_a);
          hs_n++;
        end
        if (!act_a) begin
          if (ia_first < 0) ia_first = int'(pixel_a);
          ia_n++;
        end
      end
    end
    check("line wrap seen", found, 1);
    check("wrap prev pixel", prev_p, 799);
    check("wrap pixel", int'(pixel_a), 0);
    check("wrap active", int'(act_a), 1);
    check("hsync low first", hs_first, 656);
    check("hsync low last", hs_last, 751);
    check("hsync low count", hs_n, 96);
    check("inactive first", ia_first, 640);
    check("inactive count", ia_n, 160);

    // freeze at pixel 300 with the divider two cycles into its phase
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      cyc(1);
      if (tick_a && pixel_a == 16'd300) found = 1;
    end
    check("reach pixel 300", found, 1);
    cyc(2);
    en_a = 1'b0;
    hs_snap = hs_a; vs_snap = vs_a; act_snap = act_a;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (pixel_a != 16'd300 || line_a != 16'd1 || tick_a || fs_a || vb_a ||
          hs_a != hs_snap || vs_a != vs_snap || act_a != act_snap) errs++;
    end
    check("freeze hold errors", errs, 0);
    en_a = 1'b1;
    cyc(1);
    check("resume +1 tick", int'(tick_a), 0);
    cyc(1);
    check("resume +2 tick", int'(tick_a), 1);
    check("resume +2 pixel", int'(pixel_a), 301);

    // reset in the hsync pulse overrides enable
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      cyc(1);
      if (pixel_a == 16'd700) found = 1;
    end
    check("reach pixel 700", found, 1);
    check("pre-reset hsync", int'(hs_a), 0);
    rst_a = 1'b1;
    cyc(1);
    check("mid rst pixel", int'(pixel_a), 0);
    check("mid rst line", int'(line_a), 0);
    check("mid rst hsync", int'(hs_a), 1);
    check("mid rst vsync", int'(vs_a), 1);
    check("mid rst active", int'(act_a), 1);
    check("mid rst pulses", int'(tick_a) + int'(fs_a) + int'(vb_a), 0);
    en_a = 1'b0;

    // full frame on the 14-pixel x 525-line instance
    rst_b = 1'b0; en_b = 1'b1;
    vs_first = -1; vs_last = -1; errs = 0; vb_n = 0; vb_p = -1; vb_l = -1;
    found = 0; prev_p = 0; prev_l = 0;
    for (int i = 0; i < 8000 && found == 0; i++) begin
      prev_p = int'(pixel_b);
      prev_l = int'(line_b);
      cyc(1);
      if (fs_b) begin
        found = 1;
      end else begin
        exp_bit = !(line_b >= 16'd490 && line_b < 16'd492);
        if (vs_b != exp_bit) errs++;
        if (!vs_b) begin
          if (vs_first < 0) vs_first = int'(line_b);
          vs_last = int'(line_b);
        end
      end
      if (vb_b) begin
        vb_n++;
        vb_p = int'(pixel_b);
        vb_l = int'(line_b);
      end
    end
    check("frame_start seen", found, 1);
    check("frame wrap prev pixel", prev_p, 13);
    check("frame wrap prev line", prev_l, 524);
    check("frame wrap pos", int'(pixel_b) + int'(line_b), 0);
    check("frame_count 0->1", int'(fc_b), 1);
    check("vsync per-line errors", errs, 0);
    check("vsync first line", vs_first, 490);
    check("vsync last line", vs_last, 491);
    check("vblank pulse cycles", vb_n, 1);
    check("vblank pixel", vb_p, 0);
    check("vblank line", vb_l, 480);
    cyc(1);
    check("frame_start one cycle", int'(fs_b), 0);

    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      cyc(1);
      if (line_b == 16'd300) found = 1;
    end
    check("reach line 300", found, 1);
    rst_b = 1'b1;
    cyc(1);
    check("rst_b frame_count", int'(fc_b), 0);
    check("rst_b pos", int'(pixel_b) + int'(line_b), 0);
    en_b = 1'b0;

    // corner instance: tick every cycle, active-high hsync, 98-cycle frame
    rst_c = 1'b0; en_c = 1'b1;
    n_tick = 0; errs = 0; hs_n = 0; fs1 = -1; fs2 = -1; p14 = -1; l14 = -1;
    for (int i = 1; i <= 196; i++) begin
      cyc(1);
      n_tick += int'(tick_c);
      exp_bit = (pixel_c >= 16'd10 && pixel_c < 16'd12);
      if (hs_c != exp_bit) errs++;
      hs_n += int'(hs_c);
      if (i == 14) begin
        p14 = int'(pixel_c);
        l14 = int'(line_c);
      end
      if (fs_c) begin
        if (fs1 < 0) fs1 = i;
        else fs2 = i;
      end
    end
    check("corner ticks", n_tick, 196);
    check("corner hsync errors", errs, 0);
    check("corner hsync high count", hs_n, 28);
    check("corner line wrap pixel", p14, 0);
    check("corner line wrap line", l14, 1);
    check("corner first frame", fs1, 98);
    check("corner second frame", fs2, 196);
    check("corner frame_count", int'(fc_c), 2);

    force dut_c.frame_cnt_r = 16'hFFFF;
    #1;
    release dut_c.frame_cnt_r;
    cyc(1);
    check("forced frame_count", int'(fc_c), 65535);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cyc(1);
      if (fs_c) found = 1;
    end
    check("wrap frame_start", found, 1);
    check("frame_count wrap", int'(fc_c), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
